lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit between the execute stage and data_mem; drives data_mem with word-only accesses (sb_op=lb_op=0).
//  Converts byte addresses to word indices and performs LB/LH/LW/LBU/LHU byte-lane extraction.
//  Implements SB/SH as read-modify-write and flags misaligned or out-of-range accesses without touching memory.
//  One request in flight: req_valid/req_ready in, single-cycle resp_valid pulse out.
// PARAMETERS
//  ADDR_W  8  word-index width; memory holds 2**ADDR_W 32-bit words (byte range 0 .. 4*2**ADDR_W-1)
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept request (high only in IDLE)
//  req_we         in   1   1=store, 0=load
//  req_funct3     in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data (low byte/half used for SB/SH)
//  resp_valid     out  1   one-cycle completion pulse
//  resp_rdata     out  32  load result (0 for stores and errors)
//  resp_misalign  out  1   error: misaligned access or illegal funct3
//  resp_oob       out  1   error: address beyond memory
//  mem_addr       out  32  word index to data_mem = {zero-ext, req_addr[ADDR_W+1:2]}
//  mem_we         out  1   data_mem write enable
//  mem_re         out  1   data_mem read enable
//  mem_wdata      out  32  data_mem write word
//  mem_rdata      in   32  data_mem read word, valid the cycle after mem_re
//  mem_sb_op      out  1   tied 0
//  mem_lb_op      out  1   tied 0
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, resp_rdata, resp_misalign, resp_oob, mem_we, mem_re = 0; captured regs = 0.
//  Accept on req_valid & req_ready (cycle 0): capture we/funct3/addr/wdata.
//  Error check at accept:
//   - Misaligned: H/HU with addr[0]!=0, W with addr[1:0]!=0, or funct3 in {011,110,111}, or store with funct3 100/101.
//   - OOB: addr[31:ADDR_W+2] != 0. Misalign has priority; only one error flag is set.
//  States: IDLE, RD, EXT, MERGE, WR, RESP. mem_* outputs are decoded from state plus captured regs.
//   - IDLE  -> RESP (error) | RD (load or SB/SH) | WR (SW).
//   - RD: mem_re=1 -> EXT (load) | MERGE (store).
//   - EXT: extract lane = addr[1:0] (B) or addr[1] (H); sign-extend (B/H) or zero-extend (BU/HU); register into resp_rdata -> RESP.
//   - MERGE: replace addressed byte/half of mem_rdata with wdata[7:0]/[15:0]; register into wbuf -> WR.
//   - WR: mem_we=1, mem_wdata = wdata (SW) or wbuf (SB/SH) -> RESP.
//   - RESP: resp_valid=1, req_ready=0 -> IDLE.
//  Latency, accept to resp_valid: error 1, SW 2, loads 3, SB/SH 4 cycles. Next accept is possible the cycle after RESP.
//  mem_we and mem_re are never high together; each is high for exactly one cycle per access.
//  Error response: resp_rdata=0, no mem_re/mem_we ever asserted for that request.
//  Store response: resp_rdata=0. Error flags are valid only with resp_valid, and are cleared in all other cycles.
//  Little-endian lanes: byte k = bits [8k+7:8k].
//  Reset mid-operation: rst sampled high aborts the op; state=IDLE next cycle, no resp_valid.
//   No mem_we occurs after the reset edge; memory is unchanged unless WR had already completed.
//  req_* inputs are ignored outside IDLE.
// TESTING
//  1. SW 0x12345678 @0x10, then LW @0x10 -> mem_addr=4, mem_we for 1 cycle, resp at +2; LW resp_rdata=0x12345678 at +3.
//  2. SB 0xAB @0x11 on word 0x12345678 -> word becomes 0x1234AB78, resp at +4.
//     Then LB @0x11 -> 0xFFFFFFAB; LBU @0x11 -> 0x000000AB.
//  3. SH 0x8001 @0x12 -> word 0x8001AB78; LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001.
//  4. LW @0x13 and SH @0x11 -> resp_misalign=1, resp_rdata=0 at +1; mem_re and mem_we stay 0.
//  5. LW @0x400 (ADDR_W=8) -> resp_oob=1, resp_misalign=0 at +1, no memory access.
//     LW @0x402 -> resp_misalign=1 only.
//  6. rst pulse during MERGE of SB @0x10 -> no mem_we, word unchanged, no resp_valid; req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Purpose: load/store unit between execute and data_mem. It issues word accesses and does byte/half extraction and read-modify-write.
// Latency: accept to resp_valid is 1 cycle for an error, 2 for SW, 3 for a load and 4 for SB/SH.
// Backpressure: one request in flight. req_ready is high only in IDLE, and req_* are ignored in every other state.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata request side;
//        resp_valid/resp_rdata/resp_misalign/resp_oob single-cycle response; mem_* word-only data_mem port
//        (mem_rdata arrives the cycle after mem_re; mem_sb_op/mem_lb_op are tied low).
module lsu_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              resp_oob,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_sb_op,
  output logic              mem_lb_op
);

  typedef enum logic [2:0] {IDLE, RD, EXT, MERGE, WR, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wbuf;

  logic              acc_mis;
  logic              acc_oob;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ext_data;
  logic [31:0]       merged;

  // Decode errors on the raw request. BU/HU have no store form, so a store
  // with either encoding counts as an illegal funct3.
  always_comb begin
    acc_mis = 1'b0;
    case (req_funct3)
      F3_B:         acc_mis = 1'b0;
      F3_H:         acc_mis = req_addr[0];
      F3_W:         acc_mis = |req_addr[1:0];
      F3_BU:        acc_mis = req_we;
      F3_HU:        acc_mis = req_we | req_addr[0];
      default:      acc_mis = 1'b1;
    endcase
    acc_oob = |req_addr[31:ADDR_W+2];
  end

  // Lane selection for both extraction and merge. Little-endian order: byte k is bits [8k+7:8k].
  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      F3_B:    ext_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ext_data = {24'h0, lane_b};
      F3_H:    ext_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ext_data = {16'h0, lane_h};
      default: ext_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  assign req_ready = (state == IDLE);
  assign mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign mem_wdata = (f3_q == F3_W) ? wdata_q : wbuf;
  assign mem_sb_op = 1'b0;
  assign mem_lb_op = 1'b0;

  // The strobes and response flags default low every cycle, so each one is a single-cycle pulse.
  // A synchronous reset in any state drops straight to IDLE, so a pending WR never issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= 32'h0;
      wbuf          <= 32'h0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_misalign <= 1'b0;
      resp_oob      <= 1'b0;
    end else begin
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_misalign <= 1'b0;
      resp_oob      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr[ADDR_W+1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            if (acc_mis || acc_oob) begin
              // Misalign wins, so at most one error flag is raised.
              state         <= RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= acc_mis;
              resp_oob      <= ~acc_mis;
            end else if (req_we && req_funct3 == F3_W) begin
              state  <= WR;
              mem_we <= 1'b1;
            end else begin
              state  <= RD;
              mem_re <= 1'b1;
            end
          end
        end
        RD: state <= we_q ? MERGE : EXT;
        EXT: begin
          resp_rdata <= ext_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        MERGE: begin
          wbuf   <= merged;
          mem_we <= 1'b1;
          state  <= WR;
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Purpose: directed bench for lsu_mem_ctrl. It includes a synchronous-read data_mem model.
// Latency: each request is tracked from accept to resp_valid and bounded to 20 cycles.
// Backpressure: a new request is launched only while req_ready is high.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_oob;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_sb_op;
  logic        mem_lb_op;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:255];

  lsu_mem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_oob(resp_oob),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_sb_op(mem_sb_op), .mem_lb_op(mem_lb_op)
  );

  always #5 clk = ~clk;

  // data_mem: synchronous read, so data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  // Issue one request, then watch it until it completes. While the DUT is busy, an
  // illegal-looking junk store is held on req_* so that any acceptance outside IDLE
  // corrupts memory or the strobe counts.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic mis, output logic oob, output int rc, output int wc,
                        output logic [31:0] waddr, output logic proto_err,
                        output logic rdy_after, output logic vld_after);
    lat = 0; rdata = 32'h0; mis = 1'b0; oob = 1'b0; rc = 0; wc = 0; waddr = 32'h0;
    proto_err = 1'b0; rdy_after = 1'b0; vld_after = 1'b0;
    for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_re) rc++;
      if (mem_we) begin wc++; waddr = mem_addr; end
      if (mem_re && mem_we) proto_err = 1'b1;
      if (!resp_valid && (resp_misalign || resp_oob)) proto_err = 1'b1;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; mis = resp_misalign; oob = resp_oob;
        if (req_ready) proto_err = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rdy_after = req_ready; vld_after = resp_valid;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vectors++; if ({mem_we, mem_re} !== 2'b00) begin miscompares++; $display("FAIL reset_mem_strobes got %b want 00", {mem_we, mem_re}); end
    vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    vectors++; if ({resp_misalign, resp_oob} !== 2'b00) begin miscompares++; $display("FAIL reset_err_flags got %b want 00", {resp_misalign, resp_oob}); end
    vectors++; if ({mem_sb_op, mem_lb_op} !== 2'b00) begin miscompares++; $display("FAIL reset_op_ties got %b want 00", {mem_sb_op, mem_lb_op}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d want 2", lat); end
    vectors++; if (wc !== 1 || rc !== 0) begin miscompares++; $display("FAIL sw_strobes got we=%0d re=%0d want we=1 re=0", wc, rc); end
    vectors++; if (wa !== 32'd4) begin miscompares++; $display("FAIL sw_mem_addr got %h want 4", wa); end
    vectors++; if (rd !== 32'h0 || pe !== 1'b0) begin miscompares++; $display("FAIL sw_resp got rdata=%h proto=%b want 0/0", rd, pe); end
    vectors++; if (mem[4] !== 32'h12345678) begin miscompares++; $display("FAIL sw_mem_word got %h want 12345678", mem[4]); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lw_latency got %0d want 3", lat); end
    vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL lw_rdata got %h want 12345678", rd); end
    vectors++; if (rc !== 1 || wc !== 0 || pe !== 1'b0) begin miscompares++; $display("FAIL lw_strobes got re=%0d we=%0d proto=%b want 1/0/0", rc, wc, pe); end
  endtask

  task automatic test_sb_lb();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAB, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sb_latency got %0d want 4", lat); end
    vectors++; if (rc !== 1 || wc !== 1 || pe !== 1'b0) begin miscompares++; $display("FAIL sb_strobes got re=%0d we=%0d proto=%b want 1/1/0", rc, wc, pe); end
    vectors++; if (mem[4] !== 32'h1234AB78) begin miscompares++; $display("FAIL sb_mem_word got %h want 1234ab78", mem[4]); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL sb_resp_rdata got %h want 0", rd); end
    do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'hFFFF_FFAB) begin miscompares++; $display("FAIL lb_b1 got %h want ffffffab", rd); end
    do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'h0000_00AB) begin miscompares++; $display("FAIL lbu_b1 got %h want 000000ab", rd); end
    do_req(1'b0, 3'b100, 32'h10, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'h0000_0078) begin miscompares++; $display("FAIL lbu_b0 got %h want 00000078", rd); end
  endtask

  task automatic test_sh_lh();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b1, 3'b001, 32'h12, 32'h5555_8001, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sh_latency got %0d want 4", lat); end
    vectors++; if (mem[4] !== 32'h8001AB78) begin miscompares++; $display("FAIL sh_mem_word got %h want 8001ab78", mem[4]); end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_hi got %h want ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu_hi got %h want 00008001", rd); end
    do_req(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'hFFFF_AB78) begin miscompares++; $display("FAIL lh_lo got %h want ffffab78", rd); end
    do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_b3 got %h want ffffff80", rd); end
  endtask

  task automatic test_misalign();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 1 || mis !== 1'b1 || oob !== 1'b0) begin miscompares++; $display("FAIL lw_mis got lat=%0d mis=%b oob=%b want 1/1/0", lat, mis, oob); end
    vectors++; if (rd !== 32'h0 || rc !== 0 || wc !== 0) begin miscompares++; $display("FAIL lw_mis_nomem got rdata=%h re=%0d we=%0d want 0/0/0", rd, rc, wc); end
    do_req(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 1 || mis !== 1'b1 || rc !== 0 || wc !== 0) begin miscompares++; $display("FAIL sh_mis got lat=%0d mis=%b re=%0d we=%0d want 1/1/0/0", lat, mis, rc, wc); end
    do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (mis !== 1'b1 || rc !== 0) begin miscompares++; $display("FAIL f3_011_mis got mis=%b re=%0d want 1/0", mis, rc); end
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (mis !== 1'b1 || wc !== 0 || rc !== 0) begin miscompares++; $display("FAIL store_bu_mis got mis=%b we=%0d re=%0d want 1/0/0", mis, wc, rc); end
    vectors++; if (mem[4] !== 32'h8001AB78 || pe !== 1'b0) begin miscompares++; $display("FAIL mis_mem_intact got %h proto=%b want 8001ab78/0", mem[4], pe); end
  endtask

  task automatic test_oob();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b0, 3'b010, 32'h400, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 1 || oob !== 1'b1 || mis !== 1'b0) begin miscompares++; $display("FAIL lw_oob got lat=%0d oob=%b mis=%b want 1/1/0", lat, oob, mis); end
    vectors++; if (rc !== 0 || wc !== 0 || rd !== 32'h0) begin miscompares++; $display("FAIL lw_oob_nomem got re=%0d we=%0d rdata=%h want 0/0/0", rc, wc, rd); end
    do_req(1'b0, 3'b010, 32'h402, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (mis !== 1'b1 || oob !== 1'b0) begin miscompares++; $display("FAIL lw_oob_mis_prio got mis=%b oob=%b want 1/0", mis, oob); end
    do_req(1'b1, 3'b010, 32'h3FC, 32'hDEAD_BEEF, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (wa !== 32'd255 || oob !== 1'b0 || wc !== 1) begin miscompares++; $display("FAIL sw_top_word got addr=%h oob=%b we=%0d want ff/0/1", wa, oob, wc); end
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_top_word got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, rc, wc; logic [31:0] rd, wa; logic mis, oob, pe, ra, va;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (ra !== 1'b1 || va !== 1'b0 || pe !== 1'b0) begin miscompares++; $display("FAIL b2b_after_resp got ready=%b valid=%b proto=%b want 1/0/0", ra, va, pe); end
    do_req(1'b1, 3'b010, 32'h14, 32'hCAFE_F00D, lat, rd, mis, oob, rc, wc, wa, pe, ra, va);
    vectors++; if (lat !== 2 || mem[5] !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_sw got lat=%0d word=%h want 2/cafef00d", lat, mem[5]); end
    vectors++; if (mem[4] !== 32'h8001AB78) begin miscompares++; $display("FAIL b2b_no_junk_accept got %h want 8001ab78", mem[4]); end
  endtask

  task automatic test_reset_mid();
    int wc = 0; int vc = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    for (int k = 0; k < 8; k++) begin
      if (mem_we) wc++;
      if (resp_valid) vc++;
      @(posedge clk); #1;
    end
    vectors++; if (wc !== 0 || vc !== 0) begin miscompares++; $display("FAIL rst_mid_quiet got we=%0d resp=%0d want 0/0", wc, vc); end
    vectors++; if (mem[4] !== 32'h8001AB78) begin miscompares++; $display("FAIL rst_mid_word got %h want 8001ab78", mem[4]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_lb();
    test_sh_lh();
    test_misalign();
    test_oob();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
